// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stalls, branch
// flushes and data-memory wait handling with a timeout error flag.
// Handshake: a memory access in M is pending while memreqm=1 and
// memreadym=0; the access completes in the cycle memreadym=1.
module hazard_unit #(
   parameter int REG_FILE_ADDR_WIDTH = 5,
   parameter int MEM_TIMEOUT         = 15
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rs1d,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rs2d,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rs1e,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rs2e,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rde,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rdm,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rdw,
   input  logic                           regwritem,
   input  logic                           regwritew,
   input  logic [2:0]                     resultsrce,
   input  logic                           pcsrce,
   input  logic                           memreqm,
   input  logic                           memreadym,
   output logic [1:0]                     forwardae,
   output logic [1:0]                     forwardbe,
   output logic                           stallf,
   output logic                           stalld,
   output logic                           stalle,
   output logic                           stallm,
   output logic                           flushd,
   output logic                           flushe,
   output logic                           flushw,
   output logic                           memerror,
   output logic                           dbg_memwait
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic {RUN, MEMWAIT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            pend_q, pend_d;
   logic            err_q, err_d;

   logic            lwstall;
   logic            redirect;
   logic            hold;

   // Forward select for one E-stage source: M result beats W result.
   function automatic logic [1:0] fwd_sel(input logic [REG_FILE_ADDR_WIDTH-1:0] rs);
      if (regwritem && (rdm != '0) && (rdm == rs))
         return 2'b10;
      else if (regwritew && (rdw != '0) && (rdw == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // Forwarding and load-use detection, independent of FSM state.
   always_comb begin
      forwardae = fwd_sel(rs1e);
      forwardbe = fwd_sel(rs2e);
      lwstall   = (resultsrce == 3'b001) && (rde != '0) &&
                  ((rde == rs1d) || (rde == rs2d));
   end

   // Next-state logic for the memory wait FSM and stall/flush outputs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      err_d    = err_q;
      redirect = pcsrce;
      hold     = 1'b0;
      case (state_q)
         RUN: begin
            // Reset masks a fresh wait so outputs stay in plain RUN form.
            if (memreqm && !memreadym && !rst) begin
               hold    = 1'b1;
               state_d = MEMWAIT;
               cnt_d   = CW'(1);
               pend_d  = pcsrce;
            end
         end
         MEMWAIT: begin
            // A redirect seen on entry is replayed when the wait ends.
            redirect = pcsrce | pend_q;
            if (memreadym) begin
               state_d = RUN;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else if (cnt_q == CW'(MEM_TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = RUN;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else begin
               hold  = 1'b1;
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = RUN;
      endcase

      if (hold) begin
         stallf = 1'b1;
         stalld = 1'b1;
         stalle = 1'b1;
         stallm = 1'b1;
         flushw = 1'b1;
         flushd = 1'b0;
         flushe = 1'b0;
      end else begin
         stallf = lwstall;
         stalld = lwstall;
         stalle = 1'b0;
         stallm = 1'b0;
         flushw = 1'b0;
         flushd = redirect;
         flushe = lwstall | redirect;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign memerror    = err_q;
   assign dbg_memwait = (state_q == MEMWAIT);

endmodule
